imm_encoder: RTL and testbench

Inverse of the decode-stage immediate extender. Accepts instruction fields plus a 32-bit immediate and a format code, scatters the immediate into the RISC-V bit positions, range-checks it, and emits the packed 32-bit instruction word. Used by the test-program loader and self-modifying-code test harness to build instruction memory images on-chip. Input and output are valid/ready streams decoupled by an output FIFO.

---
 rtl/imm_encoder.sv | 118 +++++++++++
 tb/tb_imm_encoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Packs instruction fields and a signed immediate into RISC-V instruction words,
// flags immediates that do not fit the format, and queues results in a small FIFO.
module imm_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        range_err,
  output logic [15:0] err_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic all_same(input logic [31:0] v, input int lo);
    logic ones;
    logic zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= lo) begin
        ones  = ones & v[i];
        zeros = zeros & ~v[i];
      end
    end
    return ones | zeros;
  endfunction

  function automatic logic [31:0] encode(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] v
  );
    logic [31:0] w;
    case (f)
      3'd0:    w = {v[11:0], s1, f3, d, op};
      3'd1:    w = {v[11:5], s2, s1, f3, v[4:0], op};
      3'd2:    w = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
      3'd3:    w = {v[31:12], d, op};
      3'd4:    w = {v[20], v[10:1], v[11], v[19:12], d, op};
      3'd5:    w = {f7, s2, s1, f3, d, op};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic range_bad(input logic [2:0] f, input logic [31:0] v);
    logic e;
    case (f)
      3'd0, 3'd1: e = ~all_same(v, 11);
      3'd2:       e = v[0] | ~all_same(v, 12);
      3'd3:       e = |v[11:0];
      3'd4:       e = v[0] | ~all_same(v, 20);
      3'd5:       e = 1'b0;
      default:    e = 1'b1;
    endcase
    return e;
  endfunction

  logic [31:0] word_p0;
  logic        err_p0;
  logic        push;
  logic        pop;
  logic [32:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  // Stage p0: combinational encode of the presented request
  assign word_p0 = encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
  assign err_p0  = range_bad(fmt, imm);

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign instr     = mem[rptr][31:0];
  assign range_err = mem[rptr][32];

  // Stage p1: FIFO storage; reset also clears entries so the head reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      err_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {err_p0, word_p0};
        wptr      <= wptr + PW'(1);
        if (err_p0 && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
      if (pop) rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed stimulus for imm_encoder, checked every cycle against a
// queue-based model that encodes from arithmetic field placement and integer ranges.
module tb_imm_encoder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        range_err;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  imm_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .range_err(range_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(
    input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
    input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
    input logic [6:0] f7, input logic [31:0] v
  );
    longint s;
    logic [31:0] w;
    logic [31:0] base;
    logic e;
    s    = longint'($signed(v));
    base = 32'(op) | (32'(d) << 7);
    case (f)
      3'd0: begin
        w = ((v & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | base;
        e = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        w = (((v >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) |
            (32'(f3) << 12) | ((v & 32'h1F) << 7) | 32'(op);
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25) |
            (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) |
            (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7) | 32'(op);
        e = (v[0] != 1'b0) || (s < -4096) || (s > 4094);
      end
      3'd3: begin
        w = (v & 32'hFFFFF000) | base;
        e = (v % 32'd4096) != 0;
      end
      3'd4: begin
        w = (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21) |
            (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12) | base;
        e = (v[0] != 1'b0) || (s < -1048576) || (s > 1048574);
      end
      3'd5: begin
        w = (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | base;
        e = 1'b0;
      end
      default: begin
        w = 32'h0;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  // Scoreboard: compare at negedge, then advance the model by the upcoming edge
  logic [32:0] q[$];
  int  m_err = 0;
  bit  started = 0;
  bit  chk_zero = 0;

  always @(negedge clk) begin
    bit do_push;
    bit do_pop;
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      chk("err_count", 32'(err_count), 32'(m_err));
      if (q.size() != 0) begin
        chk("instr", instr, q[0][31:0]);
        chk("range_err", 32'(range_err), 32'(q[0][32]));
      end else if (chk_zero) begin
        chk("instr_cleared", instr, 32'h0);
        chk("range_err_cleared", 32'(range_err), 32'h0);
      end
    end
    if (rst) begin
      q.delete();
      m_err    = 0;
      chk_zero = 1;
      started  = 1;
    end else if (started) begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        logic [32:0] m;
        m = model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
        q.push_back(m);
        if (m[32] && m_err < 65535) m_err++;
        chk_zero = 0;
      end
    end
  end

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] v);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = v;
    in_valid = 1'b1;
  endtask

  // Called just after a posedge; returns just after the edge that accepted the request
  task automatic finish_send(input string name);
    bit acc;
    acc = 0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk({name, "_accept_timeout"}, 32'h0, 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] v);
    set_req(f, op, d, s1, s2, f3, f7, v);
    finish_send("send");
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'h0);
  endtask

  int bnd[11] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                  1048574, -1048576, 1048576};

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 8191)) - 32'd4096;
      1: return $urandom;
      2: return ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 1));
      default: return 32'(bnd[$urandom_range(0, 10)]);
    endcase
  endfunction

  initial begin
    logic [32:0] m;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;

    m = model(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    chk("model_I_neg1", m[31:0], 32'hFFF00093); chk("model_I_neg1_err", 32'(m[32]), 32'h0);
    m = model(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    chk("model_B_m4", m[31:0], 32'hFE000EE3); chk("model_B_m4_err", 32'(m[32]), 32'h0);
    m = model(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd3);
    chk("model_B_m3_err", 32'(m[32]), 32'h1);
    m = model(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    chk("model_J_2048", m[31:0], 32'h001000EF);
    m = model(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
    chk("model_U", m[31:0], 32'h123452B7); chk("model_U_err", 32'(m[32]), 32'h1);
    m = model(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    chk("model_I_2048", m[31:0], 32'h80000093); chk("model_I_2048_err", 32'(m[32]), 32'h1);
    m = model(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'd5, 32'd0);
    chk("model_fmt7", m[31:0], 32'h0); chk("model_fmt7_err", 32'(m[32]), 32'h1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;

    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("I_latency_valid", 32'(out_valid), 32'h1);
    chk("I_latency_word", instr, 32'hFFF00093);
    @(posedge clk); #1;
    send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd3);
    send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    send(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    drain();

    out_ready = 1'b0;
    send(3'd5, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0);
    send(3'd1, 7'h23, 5'd0, 5'd6, 5'd7, 3'd2, 7'd0, 32'd100);
    set_req(3'd0, 7'h13, 5'd9, 5'd8, 5'd0, 3'd0, 7'd0, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready_low", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      imm = 32'd5 + 32'(i);
    end
    imm = 32'd77;
    out_ready = 1'b1;
    finish_send("third");
    drain();

    out_ready = 1'b0;
    send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_err_count", 32'(err_count), 32'h0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    drain();

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (c % 200 < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 499) == 0);
      fmt    = 3'($urandom_range(0, 7));
      opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); funct7 = 7'($urandom);
      imm    = rand_imm();
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    drain();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
